// File: rtl/row_combine_stage.sv
`default_nettype none
// ============================================================================
//  Module   : row_combine_stage
//  Purpose  : Buffers a row-sorted {row, value, valid} stream and sums the
//             values of consecutive same-row entries, emitting one word per row.
//  Revision : 1.0  initial release
// ============================================================================
module row_combine_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_ROW_IDX   = 8,
    parameter int DATA_PRECISION = 16,
    parameter int BITS_FIFO      = 2
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  global_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  next_fifo_full,
    output logic                  next_fifo_wr_en,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int c_DEPTH   = 1 << BITS_FIFO;
    localparam int c_VAL_MSB = DATA_WIDTH - 1 - BITS_ROW_IDX;
    localparam logic [DATA_WIDTH-1:0] c_FIELD_MASK =
        {{(BITS_ROW_IDX + DATA_PRECISION){1'b1}},
         {(DATA_WIDTH - BITS_ROW_IDX - DATA_PRECISION){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0]     r_mem [c_DEPTH];
    logic [BITS_FIFO:0]        r_wr_ptr;
    logic [BITS_FIFO:0]        r_rd_ptr;
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [BITS_ROW_IDX-1:0]   r_acc_row;
    logic [DATA_PRECISION-1:0] r_acc_val;

    logic                      w_empty;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_go;
    logic                      w_load;
    logic                      w_add;
    logic                      w_emit;
    logic                      w_emit_marker;
    logic [DATA_WIDTH-1:0]     w_head;
    logic [BITS_ROW_IDX-1:0]   w_h_row;
    logic [DATA_PRECISION-1:0] w_h_val;
    logic                      w_h_valid;
    logic                      w_same_row;
    logic [DATA_WIDTH-1:0]     w_acc_word;

    // ------------------------------------------------------------------
    // Input FIFO: extra pointer bit distinguishes full from empty
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[BITS_FIFO] != r_rd_ptr[BITS_FIFO]) &&
                     (r_wr_ptr[BITS_FIFO-1:0] == r_rd_ptr[BITS_FIFO-1:0]);
    assign w_push  = wr_en && !w_full;
    assign full    = w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[BITS_FIFO-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr[BITS_FIFO-1:0]];
    assign w_h_row    = w_head[DATA_WIDTH-1 -: BITS_ROW_IDX];
    assign w_h_val    = w_head[c_VAL_MSB -: DATA_PRECISION];
    assign w_h_valid  = w_head[0];
    assign w_same_row = (w_h_row == r_acc_row);
    assign w_go       = global_en && !w_empty;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_load        = 1'b0;
        w_add         = 1'b0;
        w_emit        = 1'b0;
        w_emit_marker = 1'b0;
        if (w_go) begin
            case (r_state)
                S_IDLE: begin
                    if (w_h_valid) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_ACC;
                    end else if (!next_fifo_full) begin
                        w_pop         = 1'b1;
                        w_emit        = 1'b1;
                        w_emit_marker = 1'b1;
                    end
                end
                S_ACC: begin
                    if (w_h_valid && w_same_row) begin
                        // Same-row merges never need downstream space
                        w_pop = 1'b1;
                        w_add = 1'b1;
                    end else if (!next_fifo_full) begin
                        w_emit = 1'b1;
                        if (w_h_valid) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            // Marker stays at the head and leaves from IDLE
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accumulator (modulo 2^DATA_PRECISION)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_acc_row <= '0;
            r_acc_val <= '0;
        end else if (w_load) begin
            r_acc_row <= w_h_row;
            r_acc_val <= w_h_val;
        end else if (w_add) begin
            r_acc_val <= r_acc_val + w_h_val;
        end
    end

    always_comb begin
        w_acc_word                                  = '0;
        w_acc_word[DATA_WIDTH-1 -: BITS_ROW_IDX]    = r_acc_row;
        w_acc_word[c_VAL_MSB -: DATA_PRECISION]     = r_acc_val;
        w_acc_word[0]                               = 1'b1;
    end

    assign next_fifo_wr_en = w_emit;

    always_comb begin
        data_out = '0;
        if (w_emit) begin
            data_out = w_emit_marker ? (w_head & c_FIELD_MASK) : w_acc_word;
        end
    end

endmodule
`default_nettype wire
